// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Multi-source writeback stage. Each of NUM_SRC result producers pushes
//   {rd, data, load format} into its own small FIFO. A round-robin arbiter
//   retires one entry per cycle to the single register-file write port. Load
//   sign/zero extension is applied on the retire path.
//
//   Optional feature, selected with the macro WB_BYPASS_EN:
//     When it is defined, an entry pushed into an empty FIFO that wins
//     arbitration in the same cycle goes straight into the retire register.
//     The FIFO is not written in that case. Minimum latency is 1 cycle.
//     When it is undefined, every entry passes through its FIFO. Minimum
//     latency is 2 cycles.
//
//   Handshake: a push on source i happens at a rising edge when src_valid[i]
//   and src_ready[i] are both high. src_ready[i] depends only on the
//   registered occupancy count. A pop in the same cycle does not free a slot
//   until the next cycle, so there is no combinational path from ready to
//   valid. A source must hold its payload stable while valid is high and
//   ready is low.
module writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int REG_AW     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic [NUM_SRC-1:0]        src_is_load,
  input  logic [NUM_SRC*3-1:0]      src_funct3,
  input  logic [NUM_SRC*2-1:0]      src_byte_off,
  output logic                      rf_write_en,
  output logic [REG_AW-1:0]         rf_rd_addr,
  output logic [XLEN-1:0]           rf_rd_data,
  output logic                      wb_busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SRC = PW'(NUM_SRC - 1);

  // Per-source FIFO storage. Each field has its own array.
  logic [REG_AW-1:0] q_rd      [NUM_SRC][FIFO_DEPTH];
  logic [XLEN-1:0]   q_data    [NUM_SRC][FIFO_DEPTH];
  logic              q_is_load [NUM_SRC][FIFO_DEPTH];
  logic [2:0]        q_funct3  [NUM_SRC][FIFO_DEPTH];
  logic [1:0]        q_off     [NUM_SRC][FIFO_DEPTH];

  logic [AW-1:0]     wr_ptr    [NUM_SRC];
  logic [AW-1:0]     rd_ptr    [NUM_SRC];
  logic [CW-1:0]     count     [NUM_SRC];

  logic [PW-1:0]     rr_ptr;

  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] push_req;
  logic [NUM_SRC-1:0] push_en;
  logic [NUM_SRC-1:0] pop_en;
  logic [NUM_SRC-1:0] arb_req;

  logic               grant_valid;
  logic [PW-1:0]      grant_idx;
  logic               take_bypass;

  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               sel_is_load;
  logic [2:0]         sel_funct3;
  logic [1:0]         sel_off;

  // Load extension. Misaligned offsets still use the plain byte/half select.
  // Unknown funct3 codes pass the data through unchanged.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      off);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Per-source status: occupancy flags, ready from the registered count, and push requests.
  always_comb begin
    not_empty = '0;
    src_ready = '0;
    push_req  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      not_empty[i] = (count[i] != '0);
      src_ready[i] = (count[i] != FULL_CNT);
      push_req[i]  = src_valid[i] & (count[i] != FULL_CNT);
    end
  end

  // Arbitration request set. With bypass enabled, an empty FIFO that is being
  // pushed this cycle also competes.
  always_comb begin
`ifdef WB_BYPASS_EN
    arb_req = not_empty | push_req;
`else
    arb_req = not_empty;
`endif
  end

  // Round-robin search: grant the first requester at index rr_ptr or above, wrapping.
  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!grant_valid && arb_req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(j);
      end
    end
  end

  // A grant to an empty FIFO can only come from the bypass request.
  always_comb begin
`ifdef WB_BYPASS_EN
    take_bypass = grant_valid && !not_empty[grant_idx];
`else
    take_bypass = 1'b0;
`endif
  end

  // Push and pop enables. A bypassed entry never enters its FIFO.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_en[i] = push_req[i] & ~(take_bypass & (grant_idx == PW'(i)));
      pop_en[i]  = grant_valid & (grant_idx == PW'(i)) & not_empty[i];
    end
  end

  // Retire candidate: the head of the granted FIFO, or the live source inputs on a bypass.
  always_comb begin
    sel_rd      = q_rd[grant_idx][rd_ptr[grant_idx]];
    sel_data    = q_data[grant_idx][rd_ptr[grant_idx]];
    sel_is_load = q_is_load[grant_idx][rd_ptr[grant_idx]];
    sel_funct3  = q_funct3[grant_idx][rd_ptr[grant_idx]];
    sel_off     = q_off[grant_idx][rd_ptr[grant_idx]];
    if (take_bypass) begin
      sel_rd      = src_rd[grant_idx*REG_AW +: REG_AW];
      sel_data    = src_data[grant_idx*XLEN +: XLEN];
      sel_is_load = src_is_load[grant_idx];
      sel_funct3  = src_funct3[grant_idx*3 +: 3];
      sel_off     = src_byte_off[grant_idx*2 +: 2];
    end
  end

  // FIFO payload write. The storage needs no reset because validity is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_en[i]) begin
        q_rd[i][wr_ptr[i]]      <= src_rd[i*REG_AW +: REG_AW];
        q_data[i][wr_ptr[i]]    <= src_data[i*XLEN +: XLEN];
        q_is_load[i][wr_ptr[i]] <= src_is_load[i];
        q_funct3[i][wr_ptr[i]]  <= src_funct3[i*3 +: 3];
        q_off[i][wr_ptr[i]]     <= src_byte_off[i*2 +: 2];
      end
    end
  end

  // FIFO pointers and occupancy. Reset discards every queued entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_en[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push_en[i]) - CW'(pop_en[i]);
      end
    end
  end

  // Round-robin pointer: moves past the winner, and holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
    end
  end

  // Retire register. An rd of x0 is consumed, but its write strobe is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_en <= 1'b0;
      rf_rd_addr  <= '0;
      rf_rd_data  <= '0;
    end else if (grant_valid) begin
      rf_write_en <= (sel_rd != '0);
      rf_rd_addr  <= sel_rd;
      rf_rd_data  <= sel_is_load ? load_ext(sel_data, sel_funct3, sel_off) : sel_data;
    end else begin
      rf_write_en <= 1'b0;
    end
  end

  assign wb_busy = (|not_empty) | rf_write_en;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter in the default build (bypass disabled).
module tb_writeback_arbiter;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 3;
  localparam int REG_AW  = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [NUM_SRC*XLEN-1:0]   src_data;
  logic [NUM_SRC-1:0]        src_is_load;
  logic [NUM_SRC*3-1:0]      src_funct3;
  logic [NUM_SRC*2-1:0]      src_byte_off;
  logic                      rf_write_en;
  logic [REG_AW-1:0]         rf_rd_addr;
  logic [XLEN-1:0]           rf_rd_data;
  logic                      wb_busy;

  int checks = 0;
  int errors = 0;

  // Expected retire payloads {rd, data}, one queue per source.
  logic [REG_AW+XLEN-1:0] exp_q0[$];
  logic [REG_AW+XLEN-1:0] exp_q1[$];
  logic [REG_AW+XLEN-1:0] exp_q2[$];

  writeback_arbiter #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .FIFO_DEPTH(2), .REG_AW(REG_AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_rd       (src_rd),
    .src_data     (src_data),
    .src_is_load  (src_is_load),
    .src_funct3   (src_funct3),
    .src_byte_off (src_byte_off),
    .rf_write_en  (rf_write_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .wb_busy      (wb_busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid    = '0;
    src_rd       = '0;
    src_data     = '0;
    src_is_load  = '0;
    src_funct3   = '0;
    src_byte_off = '0;
  endtask

  task automatic drive_entry(input int s, input logic [4:0] rd, input logic [31:0] d,
                             input logic ld, input logic [2:0] f3, input logic [1:0] off);
    src_valid[s]             = 1'b1;
    src_rd[s*REG_AW +: REG_AW] = rd;
    src_data[s*XLEN +: XLEN] = d;
    src_is_load[s]           = ld;
    src_funct3[s*3 +: 3]     = f3;
    src_byte_off[s*2 +: 2]   = off;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_write_en); end
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h want 00", rf_rd_addr); end
    checks++; if (rf_rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", rf_rd_data); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", wb_busy); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", src_ready); end
  endtask

  task automatic test_single_latency();
    drive_entry(0, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 2'b00);
    tick();
    clear_inputs();
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL lat_early_we: got %b want 0", rf_write_en); end
    checks++; if (wb_busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", wb_busy); end
    tick();
    checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL lat_we: got %b want 1", rf_write_en); end
    checks++; if (rf_rd_addr !== 5'd5) begin errors++; $display("FAIL lat_addr: got %h want 05", rf_rd_addr); end
    checks++; if (rf_rd_data !== 32'h0000_1234) begin errors++; $display("FAIL lat_data: got %h want 00001234", rf_rd_data); end
    tick();
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL lat_we_off: got %b want 0", rf_write_en); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b want 0", wb_busy); end
  endtask

  task automatic test_all_sources();
    logic [2:0] rdy_tab [8];
    int n [3];
    logic [REG_AW+XLEN-1:0] got;
    logic [REG_AW+XLEN-1:0] exp;
    logic have;
    int s;
    // Ready per edge, with bit i for source i, derived by hand from the occupancy sequence.
    rdy_tab = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    n = '{0, 0, 0};
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c >= 2) begin
        s = (c - 2) % 3;
        got = {rf_rd_addr, rf_rd_data};
        exp = '0;
        have = 1'b0;
        case (s)
          0: if (exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
          1: if (exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin exp = exp_q2.pop_front(); have = 1'b1; end
        endcase
        checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL rr_we c=%0d: got %b want 1", c, rf_write_en); end
        checks++; if (!have || got !== exp) begin errors++; $display("FAIL rr_entry c=%0d src=%0d: got %h want %h", c, s, got, exp); end
      end
      if (c < 8) begin
        checks++; if (src_ready !== rdy_tab[c]) begin errors++; $display("FAIL rr_ready c=%0d: got %b want %b", c, src_ready, rdy_tab[c]); end
        for (int s2 = 0; s2 < 3; s2++) begin
          drive_entry(s2, 5'(1 + s2*8 + n[s2]), 32'hA000_0000 | 32'(s2*256 + n[s2]), 1'b0, 3'b000, 2'b00);
          if (rdy_tab[c][s2]) begin
            case (s2)
              0: exp_q0.push_back({5'(1 + s2*8 + n[s2]), 32'hA000_0000 | 32'(s2*256 + n[s2])});
              1: exp_q1.push_back({5'(1 + s2*8 + n[s2]), 32'hA000_0000 | 32'(s2*256 + n[s2])});
              default: exp_q2.push_back({5'(1 + s2*8 + n[s2]), 32'hA000_0000 | 32'(s2*256 + n[s2])});
            endcase
            n[s2]++;
          end
        end
      end else begin
        clear_inputs();
      end
      tick();
    end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rr_drain_we: got %b want 0", rf_write_en); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy: got %b want 0", wb_busy); end
    checks++; if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      errors++; $display("FAIL rr_leftover: got %0d want 0", exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3_t  [10];
    logic [1:0]  off_t [10];
    logic        ld_t  [10];
    logic [31:0] exp_t [10];
    f3_t  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b101, 3'b011, 3'b000, 3'b000, 3'b000};
    off_t = '{2'd3,   2'd1,   2'd2,   2'd0,   2'd0,   2'd3,   2'd2,   2'd3,   2'd0,   2'd2};
    ld_t  = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1};
    exp_t = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01,
              32'h0000_80FF, 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001, 32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      drive_entry(1, 5'(3 + i), 32'h80FF_7F01, ld_t[i], f3_t[i], off_t[i]);
      tick();
      clear_inputs();
      tick();
      checks++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'(3 + i)) begin
        errors++; $display("FAIL ext_we_%0d: got we=%b rd=%0d want we=1 rd=%0d", i, rf_write_en, rf_rd_addr, 3 + i);
      end
      checks++; if (rf_rd_data !== exp_t[i]) begin
        errors++; $display("FAIL ext_data_%0d: got %h want %h", i, rf_rd_data, exp_t[i]);
      end
    end
    tick();
  endtask

  task automatic test_rd_zero();
    drive_entry(0, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'b00);
    tick();
    drive_entry(0, 5'd7, 32'h0000_0077, 1'b0, 3'b000, 2'b00);
    tick();
    clear_inputs();
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", rf_write_en); end
    checks++; if (rf_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_data: got %h want deadbeef", rf_rd_data); end
    tick();
    checks++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'd7) begin
      errors++; $display("FAIL x0_next: got we=%b rd=%0d want we=1 rd=7", rf_write_en, rf_rd_addr);
    end
    checks++; if (rf_rd_data !== 32'h0000_0077) begin errors++; $display("FAIL x0_next_data: got %h want 00000077", rf_rd_data); end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) drive_entry(s, 5'(20 + s), 32'h5000_0000 | 32'(c*16 + s), 1'b0, 3'b000, 2'b00);
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b want 0", rf_write_en); end
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL mid_rst_addr: got %h want 00", rf_rd_addr); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", wb_busy); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL mid_rst_ready: got %b want 111", src_ready); end
    for (int s = 0; s < 3; s++) drive_entry(s, 5'(11 + s), 32'h0000_00C0 + 32'(s), 1'b0, 3'b000, 2'b00);
    tick();
    clear_inputs();
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL post_rst_early: got %b want 0", rf_write_en); end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'(11 + s) || rf_rd_data !== 32'h0000_00C0 + 32'(s)) begin
        errors++; $display("FAIL post_rst_grant_%0d: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                           s, rf_write_en, rf_rd_addr, rf_rd_data, 11 + s, 32'h0000_00C0 + 32'(s));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        checks++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'(24 + c - 2) || rf_rd_data !== 32'h0000_0600 + 32'(c - 2)) begin
          errors++; $display("FAIL b2b_%0d: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                             c - 2, rf_write_en, rf_rd_addr, rf_rd_data, 24 + c - 2, 32'h0000_0600 + 32'(c - 2));
        end
      end
      if (c < 4) begin
        checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", c, src_ready[2]); end
        drive_entry(2, 5'(24 + c), 32'h0000_0600 + 32'(c), 1'b0, 3'b000, 2'b00);
      end else begin
        clear_inputs();
      end
      tick();
    end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL b2b_end_we: got %b want 0", rf_write_en); end
    // The pointer must be back at 0, so src0 wins a simultaneous push against src1.
    drive_entry(0, 5'd9, 32'h0000_0900, 1'b0, 3'b000, 2'b00);
    drive_entry(1, 5'd10, 32'h0000_0A00, 1'b0, 3'b000, 2'b00);
    tick();
    clear_inputs();
    tick();
    checks++; if (rf_rd_addr !== 5'd9) begin errors++; $display("FAIL b2b_ptr_first: got rd=%0d want 9", rf_rd_addr); end
    tick();
    checks++; if (rf_rd_addr !== 5'd10) begin errors++; $display("FAIL b2b_ptr_second: got rd=%0d want 10", rf_rd_addr); end
    tick();
  endtask

  // Sequence and final report
  initial begin
    clear_inputs();
    test_reset();
    test_single_latency();
    test_all_sources();
    test_load_ext();
    test_rd_zero();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
